// File: rtl/raster_pkg.sv
// ---------------------------------------------------------------------------
// raster_pkg
// Shared definitions for the raster bounding-box walker:
//   - default screen geometry and fixed-point format
//   - coordinate width (signed fixed point) and pixel-index width
//   - walker FSM state encoding
//   - signed min/max helpers over three vertices
// ---------------------------------------------------------------------------
package raster_pkg;

    localparam int SCREEN_W_DEFAULT  = 640;
    localparam int SCREEN_H_DEFAULT  = 480;
    localparam int FRAC_BITS_DEFAULT = 6;

    localparam int COORD_W = 16;   // signed fixed-point vertex / sample width
    localparam int PIX_W   = 10;   // integer pixel index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2
    } state_t;

    function automatic logic signed [COORD_W-1:0] min3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c
    );
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        m = (m < c) ? m : c;
        return m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c
    );
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/bbox_setup.sv
// ---------------------------------------------------------------------------
// bbox_setup
// Purely combinational bounding-box computation for one triangle.
// Per axis: min/max of the three vertex coordinates, arithmetic shift down to
// integer pixels (floor), clamp to the screen, and an empty flag.
//
// Ports:
//   v0x..v2y   in   signed fixed-point vertex coordinates
//   xmin/xmax  out  clamped integer column range
//   ymin/ymax  out  clamped integer row range
//   empty      out  bbox lies fully off-screen or is inverted after clamping
// ---------------------------------------------------------------------------
module bbox_setup
    import raster_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int SCREEN_H  = SCREEN_H_DEFAULT,
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic signed [COORD_W-1:0] v0x,
    input  logic signed [COORD_W-1:0] v0y,
    input  logic signed [COORD_W-1:0] v1x,
    input  logic signed [COORD_W-1:0] v1y,
    input  logic signed [COORD_W-1:0] v2x,
    input  logic signed [COORD_W-1:0] v2y,
    output logic        [PIX_W-1:0]   xmin,
    output logic        [PIX_W-1:0]   xmax,
    output logic        [PIX_W-1:0]   ymin,
    output logic        [PIX_W-1:0]   ymax,
    output logic                      empty
);

    // Axis 0 is x, axis 1 is y.
    logic signed [COORD_W-1:0] coord    [2][3];
    logic signed [COORD_W-1:0] lo_int   [2];
    logic signed [COORD_W-1:0] hi_int   [2];
    logic        [PIX_W-1:0]   lo_clamp [2];
    logic        [PIX_W-1:0]   hi_clamp [2];
    logic        [1:0]         off_screen;
    logic        [1:0]         inverted;

    assign coord[0][0] = v0x;
    assign coord[0][1] = v1x;
    assign coord[0][2] = v2x;
    assign coord[1][0] = v0y;
    assign coord[1][1] = v1y;
    assign coord[1][2] = v2y;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int LIMIT = (gi == 0) ? SCREEN_W : SCREEN_H;
            localparam logic signed [COORD_W-1:0] LIMIT_S = COORD_W'(LIMIT);
            localparam logic signed [COORD_W-1:0] MAX_S   = COORD_W'(LIMIT - 1);
            localparam logic signed [COORD_W-1:0] ZERO_S  = '0;

            // Arithmetic shift floors negative coordinates toward -inf, so a
            // vertex at -0.5 px lands in column -1, not column 0.
            assign lo_int[gi] = min3(coord[gi][0], coord[gi][1], coord[gi][2]) >>> FRAC_BITS;
            assign hi_int[gi] = max3(coord[gi][0], coord[gi][1], coord[gi][2]) >>> FRAC_BITS;

            // Off-screen is judged on the unclamped range; clamping alone
            // would fold a wholly off-screen box onto the screen edge.
            assign off_screen[gi] = (hi_int[gi] < ZERO_S) || (lo_int[gi] >= LIMIT_S);

            assign lo_clamp[gi] = (lo_int[gi] < ZERO_S) ? '0 :
                                  (lo_int[gi] > MAX_S)  ? MAX_S[PIX_W-1:0] :
                                                          lo_int[gi][PIX_W-1:0];
            assign hi_clamp[gi] = (hi_int[gi] < ZERO_S) ? '0 :
                                  (hi_int[gi] > MAX_S)  ? MAX_S[PIX_W-1:0] :
                                                          hi_int[gi][PIX_W-1:0];

            assign inverted[gi] = lo_clamp[gi] > hi_clamp[gi];
        end
    endgenerate

    assign xmin  = lo_clamp[0];
    assign xmax  = hi_clamp[0];
    assign ymin  = lo_clamp[1];
    assign ymax  = hi_clamp[1];
    assign empty = (|off_screen) || (|inverted);

endmodule

// File: rtl/raster_bbox_walker.sv
// ---------------------------------------------------------------------------
// raster_bbox_walker
// Accepts a triangle, computes its screen-clamped bounding box and walks every
// pixel of that box in row-major order, offering one pixel-centre sample point
// per cycle to the downstream stage through a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tri_valid / tri_ready   triangle handshake (ready only when idle)
//   v0x..v2y                signed fixed-point vertices of the offered triangle
//   t_v0x..t_v2y            vertices latched at accept, held until next accept
//   pix_valid / pix_ready   sample-point handshake
//   px, py                  fixed-point pixel-centre sample coordinates
//   pix_x, pix_y            integer pixel column / row
//   pix_last                final pixel of the current triangle
//   busy                    triangle in setup or scan
//
// Timing: accept cycle -> SETUP cycle (bbox registered, first pixel loaded)
// -> first pix_valid two cycles after accept.
// ---------------------------------------------------------------------------
module raster_bbox_walker
    import raster_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int SCREEN_H  = SCREEN_H_DEFAULT,
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      tri_valid,
    output logic                      tri_ready,
    input  logic signed [COORD_W-1:0] v0x,
    input  logic signed [COORD_W-1:0] v0y,
    input  logic signed [COORD_W-1:0] v1x,
    input  logic signed [COORD_W-1:0] v1y,
    input  logic signed [COORD_W-1:0] v2x,
    input  logic signed [COORD_W-1:0] v2y,

    output logic signed [COORD_W-1:0] t_v0x,
    output logic signed [COORD_W-1:0] t_v0y,
    output logic signed [COORD_W-1:0] t_v1x,
    output logic signed [COORD_W-1:0] t_v1y,
    output logic signed [COORD_W-1:0] t_v2x,
    output logic signed [COORD_W-1:0] t_v2y,

    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic        [COORD_W-1:0] px,
    output logic        [COORD_W-1:0] py,
    output logic        [PIX_W-1:0]   pix_x,
    output logic        [PIX_W-1:0]   pix_y,
    output logic                      pix_last,
    output logic                      busy
);

    localparam int HALF_PIX = 1 << (FRAC_BITS - 1);

    // Pixel index -> fixed-point pixel centre.
    function automatic logic [COORD_W-1:0] centre(input logic [PIX_W-1:0] idx);
        return (COORD_W'(idx) << FRAC_BITS) + COORD_W'(HALF_PIX);
    endfunction

    state_t            state_reg;
    state_t            state_next;

    logic [PIX_W-1:0]  bb_xmin;
    logic [PIX_W-1:0]  bb_xmax;
    logic [PIX_W-1:0]  bb_ymin;
    logic [PIX_W-1:0]  bb_ymax;
    logic              bb_empty;

    // Walk limits captured in SETUP; ymin is not needed once the walk starts.
    logic [PIX_W-1:0]  xmin_reg;
    logic [PIX_W-1:0]  xmax_reg;
    logic [PIX_W-1:0]  ymax_reg;

    logic [PIX_W-1:0]  x_next;
    logic [PIX_W-1:0]  y_next;
    logic              last_next;

    logic              accept;
    logic              advance;

    assign accept  = tri_valid && tri_ready;
    assign advance = pix_valid && pix_ready;

    // -----------------------------------------------------------------------
    // Bounding box from the latched vertices (valid during SETUP).
    // -----------------------------------------------------------------------
    bbox_setup #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .FRAC_BITS (FRAC_BITS)
    ) u_bbox_setup (
        .v0x   (t_v0x),
        .v0y   (t_v0y),
        .v1x   (t_v1x),
        .v1y   (t_v1y),
        .v2x   (t_v2x),
        .v2y   (t_v2y),
        .xmin  (bb_xmin),
        .xmax  (bb_xmax),
        .ymin  (bb_ymin),
        .ymax  (bb_ymax),
        .empty (bb_empty)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)               state_next = SETUP;
            SETUP:   state_next = bb_empty ? IDLE : SCAN;
            SCAN:    if (advance && pix_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state, so glitch-free and
    // correct while reset is held)
    // -----------------------------------------------------------------------
    always_comb begin
        tri_ready = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            IDLE:    tri_ready = 1'b1;
            SETUP:   busy      = 1'b1;
            SCAN:    busy      = 1'b1;
            default: tri_ready = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Vertex latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_v0x <= '0;
            t_v0y <= '0;
            t_v1x <= '0;
            t_v1y <= '0;
            t_v2x <= '0;
            t_v2y <= '0;
        end else if (accept) begin
            t_v0x <= v0x;
            t_v0y <= v0y;
            t_v1x <= v1x;
            t_v1y <= v1y;
            t_v2x <= v2x;
            t_v2y <= v2y;
        end
    end

    // -----------------------------------------------------------------------
    // Row-major step: wrap x back to xmin and bump y at the end of a row.
    // last_next looks one pixel ahead so pix_last is registered alongside
    // the pixel it belongs to.
    // -----------------------------------------------------------------------
    always_comb begin
        if (pix_x == xmax_reg) begin
            x_next = xmin_reg;
            y_next = pix_y + PIX_W'(1);
        end else begin
            x_next = pix_x + PIX_W'(1);
            y_next = pix_y;
        end
        last_next = (x_next == xmax_reg) && (y_next == ymax_reg);
    end

    // -----------------------------------------------------------------------
    // Pixel counters and registered sample outputs. Nothing changes while a
    // pixel is offered but not taken, which keeps outputs stable on stalls.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_reg  <= '0;
            xmax_reg  <= '0;
            ymax_reg  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            px        <= '0;
            py        <= '0;
            pix_last  <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            case (state_reg)
                SETUP: begin
                    if (!bb_empty) begin
                        xmin_reg  <= bb_xmin;
                        xmax_reg  <= bb_xmax;
                        ymax_reg  <= bb_ymax;
                        pix_x     <= bb_xmin;
                        pix_y     <= bb_ymin;
                        px        <= centre(bb_xmin);
                        py        <= centre(bb_ymin);
                        pix_last  <= (bb_xmin == bb_xmax) && (bb_ymin == bb_ymax);
                        pix_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                        end else begin
                            pix_x    <= x_next;
                            pix_y    <= y_next;
                            px       <= centre(x_next);
                            py       <= centre(y_next);
                            pix_last <= last_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_bbox_walker.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for raster_bbox_walker (default geometry
// 640x480, 6 fractional bits). Inputs change on the falling edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_raster_bbox_walker;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tri_valid;
    logic               tri_ready;
    logic signed [15:0] v0x, v0y, v1x, v1y, v2x, v2y;
    logic signed [15:0] t_v0x, t_v0y, t_v1x, t_v1y, t_v2x, t_v2y;
    logic               pix_valid;
    logic               pix_ready;
    logic        [15:0] px, py;
    logic        [9:0]  pix_x, pix_y;
    logic               pix_last;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;

    // Capture of one pixel stream
    int cap_x[$];
    int cap_y[$];
    int cap_px[$];
    int cap_py[$];
    int cap_last[$];
    int first_valid;
    int stall_bad;
    int stall_cycles;
    bit timed_out;

    // Expected pixel stream
    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

    raster_bbox_walker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .v0x       (v0x),
        .v0y       (v0y),
        .v1x       (v1x),
        .v1y       (v1y),
        .v2x       (v2x),
        .v2y       (v2y),
        .t_v0x     (t_v0x),
        .t_v0y     (t_v0y),
        .t_v1x     (t_v1x),
        .t_v1y     (t_v1y),
        .t_v2x     (t_v2x),
        .t_v2y     (t_v2y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .px        (px),
        .py        (py),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic drive_tri(input int ax, input int ay, input int bx,
                             input int by, input int cx, input int cy);
        v0x = 16'(ax); v0y = 16'(ay);
        v1x = 16'(bx); v1y = 16'(by);
        v2x = 16'(cx); v2y = 16'(cy);
    endtask

    // Offer a triangle and return on the falling edge after the accept edge.
    task automatic send_tri(input int ax, input int ay, input int bx,
                            input int by, input int cx, input int cy);
        int waited;
        drive_tri(ax, ay, bx, by, cx, cy);
        tri_valid = 1'b1;
        waited = 0;
        while (tri_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (tri_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL tri_accept_timeout: tri_ready=%b after %0d cycles, expected 1", tri_ready, waited);
        end
        @(negedge clk);
        tri_valid = 1'b0;
    endtask

    // Consume pixels until the pix_last handshake (or stop_after handshakes
    // when non-zero); returns on the falling edge after the final handshake.
    task automatic collect(input bit random_ready, input int stop_after, input int budget);
        int  hx, hy, hpx, hpy, hl;
        bit  have_prev;
        cap_x.delete(); cap_y.delete(); cap_px.delete(); cap_py.delete(); cap_last.delete();
        first_valid  = -1;
        stall_bad    = 0;
        stall_cycles = 0;
        timed_out    = 1'b1;
        have_prev    = 1'b0;
        hx = 0; hy = 0; hpx = 0; hpy = 0; hl = 0;
        for (int c = 0; c < budget; c++) begin
            if (have_prev) begin
                if (pix_valid !== 1'b1 || int'(pix_x) != hx || int'(pix_y) != hy ||
                    int'(px) != hpx || int'(py) != hpy || int'(pix_last) != hl)
                    stall_bad++;
                have_prev = 1'b0;
            end
            pix_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                if (pix_ready) begin
                    cap_x.push_back(int'(pix_x));
                    cap_y.push_back(int'(pix_y));
                    cap_px.push_back(int'(px));
                    cap_py.push_back(int'(py));
                    cap_last.push_back(int'(pix_last));
                    if (pix_last === 1'b1 || (stop_after > 0 && cap_x.size() == stop_after)) begin
                        @(negedge clk);
                        pix_ready = 1'b1;
                        timed_out = 1'b0;
                        break;
                    end
                end else begin
                    stall_cycles++;
                    hx = int'(pix_x); hy = int'(pix_y);
                    hpx = int'(px);   hpy = int'(py);
                    hl = int'(pix_last);
                    have_prev = 1'b1;
                end
            end
            @(negedge clk);
        end
        pix_ready = 1'b1;
    endtask

    task automatic build_exp(input int xmin, input int xmax, input int ymin, input int ymax);
        exp_x.delete();
        exp_y.delete();
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0; tri_valid = 1'b0; pix_ready = 1'b1;
        drive_tri(0, 0, 0, 0, 0, 0);
        #12;
        vectors++;
        if (tri_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: tri_ready=%b busy=%b, expected 1 0", tri_ready, busy);
        end
        vectors++;
        if (pix_valid !== 1'b0 || pix_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: pix_valid=%b pix_last=%b, expected 0 0", pix_valid, pix_last);
        end
        vectors++;
        if (px !== 16'd0 || py !== 16'd0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_coords: px=%0d py=%0d pix_x=%0d pix_y=%0d, expected all 0", px, py, pix_x, pix_y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: tri_ready=%b busy=%b pix_valid=%b", tri_ready, busy, pix_valid);
    endtask

    task automatic test_basic();
        send_tri(128, 128, 320, 128, 128, 256);
        vectors++;
        if (busy !== 1'b1 || tri_ready !== 1'b0 || pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_setup: busy=%b tri_ready=%b pix_valid=%b, expected 1 0 0", busy, tri_ready, pix_valid);
        end
        vectors++;
        if (t_v1x !== 16'(320) || t_v2y !== 16'(256)) begin
            miscompares++;
            $display("FAIL basic_latch: t_v1x=%0d t_v2y=%0d, expected 320 256", t_v1x, t_v2y);
        end
        collect(1'b0, 0, 200);
        $display("tri basic: %0d pixels, first pix_valid %0d cycles after accept", cap_x.size(), first_valid + 1);
        vectors++;
        if (timed_out || first_valid != 1) begin
            miscompares++;
            $display("FAIL basic_latency: timed_out=%0d first_valid_offset=%0d, expected 0 1", timed_out, first_valid);
        end
        build_exp(2, 5, 2, 4);
        vectors++;
        if (cap_x.size() != exp_x.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d pixels, expected %0d", cap_x.size(), exp_x.size());
        end
        for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
            vectors++;
            if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_px[i] != exp_x[i]*64+32 ||
                cap_py[i] != exp_y[i]*64+32 || cap_last[i] != int'(i == exp_x.size()-1)) begin
                miscompares++;
                $display("FAIL basic_pix[%0d]: got (%0d,%0d) px=%0d py=%0d last=%0d, expected (%0d,%0d) px=%0d py=%0d last=%0d",
                         i, cap_x[i], cap_y[i], cap_px[i], cap_py[i], cap_last[i],
                         exp_x[i], exp_y[i], exp_x[i]*64+32, exp_y[i]*64+32, int'(i == exp_x.size()-1));
            end
        end
        vectors++;
        if (cap_px.size() == 12 && (cap_px[0] != 160 || cap_py[0] != 160 || cap_px[11] != 352 || cap_py[11] != 288)) begin
            miscompares++;
            $display("FAIL basic_ends: first px/py=%0d/%0d last px/py=%0d/%0d, expected 160/160 352/288",
                     cap_px[0], cap_py[0], cap_px[11], cap_py[11]);
        end
        vectors++;
        if (pix_valid !== 1'b0 || tri_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: pix_valid=%b tri_ready=%b busy=%b, expected 0 1 0", pix_valid, tri_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        send_tri(128, 128, 320, 128, 128, 256);
        collect(1'b1, 0, 400);
        $display("tri backpressure: %0d pixels, %0d stall cycles", cap_x.size(), stall_cycles);
        build_exp(2, 5, 2, 4);
        vectors++;
        if (timed_out || cap_x.size() != exp_x.size()) begin
            miscompares++;
            $display("FAIL bp_count: got %0d pixels timed_out=%0d, expected %0d 0", cap_x.size(), timed_out, exp_x.size());
        end
        for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
            vectors++;
            if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_px[i] != exp_x[i]*64+32 ||
                cap_py[i] != exp_y[i]*64+32 || cap_last[i] != int'(i == exp_x.size()-1)) begin
                miscompares++;
                $display("FAIL bp_pix[%0d]: got (%0d,%0d) px=%0d py=%0d last=%0d, expected (%0d,%0d) last=%0d",
                         i, cap_x[i], cap_y[i], cap_px[i], cap_py[i], cap_last[i],
                         exp_x[i], exp_y[i], int'(i == exp_x.size()-1));
            end
        end
        vectors++;
        if (stall_bad != 0 || stall_cycles == 0) begin
            miscompares++;
            $display("FAIL bp_stable: %0d unstable stalls of %0d, expected 0 of >0", stall_bad, stall_cycles);
        end
    endtask

    task automatic test_clip();
        // Max vertex 63 >>> 6 = 0, so the clamped box is just (0,0).
        send_tri(-640, -640, 63, -640, -640, 63);
        collect(1'b0, 0, 100);
        $display("tri clip_single: %0d pixels", cap_x.size());
        vectors++;
        if (timed_out || cap_x.size() != 1) begin
            miscompares++;
            $display("FAIL clip_single_count: got %0d pixels timed_out=%0d, expected 1 0", cap_x.size(), timed_out);
        end else begin
            vectors++;
            if (cap_x[0] != 0 || cap_y[0] != 0 || cap_px[0] != 32 || cap_py[0] != 32 || cap_last[0] != 1) begin
                miscompares++;
                $display("FAIL clip_single_pix: got (%0d,%0d) px=%0d py=%0d last=%0d, expected (0,0) 32 32 1",
                         cap_x[0], cap_y[0], cap_px[0], cap_py[0], cap_last[0]);
            end
        end
        // 64 >>> 6 = 1, so the box reaches column/row 1: a 2x2 block.
        send_tri(-640, -640, 64, -640, -640, 64);
        collect(1'b0, 0, 100);
        $display("tri clip_quad: %0d pixels", cap_x.size());
        build_exp(0, 1, 0, 1);
        vectors++;
        if (timed_out || cap_x.size() != exp_x.size()) begin
            miscompares++;
            $display("FAIL clip_quad_count: got %0d pixels timed_out=%0d, expected %0d 0", cap_x.size(), timed_out, exp_x.size());
        end
        for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
            vectors++;
            if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_px[i] != exp_x[i]*64+32 ||
                cap_last[i] != int'(i == exp_x.size()-1)) begin
                miscompares++;
                $display("FAIL clip_quad_pix[%0d]: got (%0d,%0d) px=%0d last=%0d, expected (%0d,%0d) px=%0d last=%0d",
                         i, cap_x[i], cap_y[i], cap_px[i], cap_last[i],
                         exp_x[i], exp_y[i], exp_x[i]*64+32, int'(i == exp_x.size()-1));
            end
        end
    endtask

    task automatic test_offscreen();
        int seen;
        // Case 0: every y at or beyond row 480; case 1: every x left of column 0.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send_tri(0, 30720, 100, 31000, 200, 32000);
            else        send_tri(-64, 0, -128, 64, -200, 100);
            seen = int'(pix_valid);
            vectors++;
            if (busy !== 1'b1 || tri_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL offscreen%0d_setup: busy=%b tri_ready=%b, expected 1 0", k, busy, tri_ready);
            end
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || tri_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL offscreen%0d_return: busy=%b tri_ready=%b, expected 0 1", k, busy, tri_ready);
            end
            for (int c = 0; c < 5; c++) begin
                if (pix_valid === 1'b1) seen++;
                @(negedge clk);
            end
            vectors++;
            if (seen != 0) begin
                miscompares++;
                $display("FAIL offscreen%0d_pixels: pix_valid seen %0d cycles, expected 0", k, seen);
            end
            $display("tri offscreen%0d: 0 pixels expected, %0d valid cycles seen", k, seen);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        send_tri(128, 128, 320, 128, 128, 256);
        collect(1'b0, 5, 100);
        vectors++;
        if (timed_out || cap_x.size() != 5 || cap_x[4] != 2 || cap_y[4] != 3) begin
            miscompares++;
            $display("FAIL midrst_prefix: got %0d pixels timed_out=%0d, expected 5 ending at (2,3)", cap_x.size(), timed_out);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pix_valid !== 1'b0 || tri_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_ctrl: pix_valid=%b tri_ready=%b busy=%b, expected 0 1 0", pix_valid, tri_ready, busy);
        end
        vectors++;
        if (t_v0x !== 16'd0 || t_v1x !== 16'd0 || t_v2y !== 16'd0 || pix_x !== 10'd0 || px !== 16'd0) begin
            miscompares++;
            $display("FAIL midrst_regs: t_v0x=%0d t_v1x=%0d t_v2y=%0d pix_x=%0d px=%0d, expected all 0",
                     t_v0x, t_v1x, t_v2y, pix_x, px);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pix_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || tri_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after: pix_valid seen %0d cycles tri_ready=%b, expected 0 1", seen, tri_ready);
        end
        $display("tri reset_mid_scan: %0d pixels before reset, %0d after", cap_x.size(), seen);
    endtask

    task automatic test_back_to_back();
        send_tri(128, 128, 320, 128, 128, 256);
        // Second triangle offered (different vertex order) during the first scan.
        drive_tri(200, 70, 70, 200, 135, 135);
        tri_valid = 1'b1;
        collect(1'b0, 0, 200);
        $display("tri b2b_first: %0d pixels", cap_x.size());
        vectors++;
        if (timed_out || cap_x.size() != 12 || cap_last[cap_x.size()-1] != 1) begin
            miscompares++;
            $display("FAIL b2b_first: got %0d pixels timed_out=%0d, expected 12 0", cap_x.size(), timed_out);
        end
        vectors++;
        if (tri_ready !== 1'b1 || pix_valid !== 1'b0 || t_v0x !== 16'(128)) begin
            miscompares++;
            $display("FAIL b2b_gap: tri_ready=%b pix_valid=%b t_v0x=%0d, expected 1 0 128", tri_ready, pix_valid, t_v0x);
        end
        @(negedge clk);
        tri_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || t_v0x !== 16'(200) || t_v1y !== 16'(200)) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b t_v0x=%0d t_v1y=%0d, expected 1 200 200", busy, t_v0x, t_v1y);
        end
        collect(1'b0, 0, 200);
        $display("tri b2b_second: %0d pixels", cap_x.size());
        build_exp(1, 3, 1, 3);
        vectors++;
        if (timed_out || first_valid != 1 || cap_x.size() != exp_x.size()) begin
            miscompares++;
            $display("FAIL b2b_second_count: got %0d pixels first_valid=%0d timed_out=%0d, expected %0d 1 0",
                     cap_x.size(), first_valid, timed_out, exp_x.size());
        end
        for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
            vectors++;
            if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_px[i] != exp_x[i]*64+32 ||
                cap_py[i] != exp_y[i]*64+32 || cap_last[i] != int'(i == exp_x.size()-1)) begin
                miscompares++;
                $display("FAIL b2b_pix[%0d]: got (%0d,%0d) px=%0d py=%0d last=%0d, expected (%0d,%0d) last=%0d",
                         i, cap_x[i], cap_y[i], cap_px[i], cap_py[i], cap_last[i],
                         exp_x[i], exp_y[i], int'(i == exp_x.size()-1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clip();
        test_offscreen();
        test_reset_mid_scan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
